isp_mode_ctrl: RTL

Parametrised ISP display-mode controller that supersedes the bare button edge counter in the top level. It debounces the user button in the 50 MHz system domain and distinguishes short presses (next mode) from long presses (return to mode 0). Each mode change crosses into the video/pixel clock domain through a toggle handshake and is applied only on a frame boundary. It drives `isp_disp_mode` of the ISP so mode switches never tear a frame.

---
 rtl/isp_ctrl_pkg.sv | 16 +
 rtl/button_debounce.sv | 73 +++++++
 rtl/isp_mode_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/isp_ctrl_pkg.sv
// Shared constants and types for the ISP display-mode controller.
// Mode codes and the press-FSM state encoding.
package isp_ctrl_pkg;

  localparam logic [3:0] MODE_GAMMA = 4'd0;
  localparam logic [3:0] MODE_RAW   = 4'd1;
  localparam logic [3:0] MODE_CFA   = 4'd2;
  localparam logic [3:0] MODE_CCM   = 4'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } press_state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-button synchroniser and debouncer; reports a clean "pressed" level.
// The output stays low after reset until the button has been seen released.
module button_debounce #(
  parameter int   DEBOUNCE_CYC = 1_000_000,
  parameter logic BTN_ACTIVE   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic pressed
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  logic             level_r;
  logic             armed_r;
  logic [1:0]       vld_r;
  logic [CNT_W-1:0] cnt_r;
  logic             raw_s;

  assign raw_s = (sync2_r == BTN_ACTIVE);

  // Two-stage synchroniser; idles at the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= ~BTN_ACTIVE;
      sync2_r <= ~BTN_ACTIVE;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter: any flip or agreement restarts it; a full run flips the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r  <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      prev_r <= raw_s;
      if ((raw_s == level_r) || (raw_s != prev_r)) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_r <= raw_s;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // A press held through reset must be released before presses count again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_r   <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      vld_r <= {vld_r[0], 1'b1};
      if (vld_r[1] && !raw_s && !level_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign pressed = level_r & armed_r;

endmodule

// File: rtl/isp_mode_ctrl.sv
// ISP display-mode controller: short press = next mode, long press = mode 0.
// Mode crosses to vid_clk by toggle handshake and is applied on a vsync edge.
module isp_mode_ctrl
  import isp_ctrl_pkg::*;
#(
  parameter int   NUM_MODES    = 4,
  parameter int   MODE_W       = 4,
  parameter int   DEBOUNCE_CYC = 1_000_000,
  parameter int   LONG_CYC     = 50_000_000,
  parameter logic BTN_ACTIVE   = 1'b1,
  parameter logic VSYNC_POL    = 1'b1
) (
  input  logic              clk,
  input  logic              vid_clk,
  input  logic              reset_n,
  input  logic              button,
  input  logic              vid_vsync,
  output logic [MODE_W-1:0] mode_sys,
  output logic              long_press,
  output logic [MODE_W-1:0] mode_out,
  output logic              mode_changed
);

  localparam int              HOLD_W    = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(MODE_GAMMA);

  logic [1:0]        sys_rst_r;
  logic [1:0]        vid_rst_r;
  logic              sys_rst_n_s;
  logic              vid_rst_n_s;
  logic              pressed_s;

  press_state_t      state_r, state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic [MODE_W-1:0] mode_sys_r, mode_sys_nxt_s;
  logic              long_press_r, long_press_nxt_s;

  logic [MODE_W-1:0] sent_r, xfer_data_r;
  logic              req_tgl_r, busy_r;
  logic [2:0]        ack_sync_r;

  logic [2:0]        req_sync_r;
  logic              cap_s;
  logic              ack_tgl_r, pend_r;
  logic [MODE_W-1:0] pend_mode_r, mode_out_r;
  logic              vs_in_r, vs_prev_r, vs_edge_r, mode_changed_r;

  // Per-domain reset: asserts immediately, releases two clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sys_rst_r <= 2'b00;
    else          sys_rst_r <= {sys_rst_r[0], 1'b1};
  end

  always_ff @(posedge vid_clk or negedge reset_n) begin
    if (!reset_n) vid_rst_r <= 2'b00;
    else          vid_rst_r <= {vid_rst_r[0], 1'b1};
  end

  assign sys_rst_n_s = sys_rst_r[1];
  assign vid_rst_n_s = vid_rst_r[1];

  button_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .BTN_ACTIVE   (BTN_ACTIVE)
  ) u_debounce (
    .clk     (clk),
    .reset_n (sys_rst_n_s),
    .button  (button),
    .pressed (pressed_s)
  );

  // Press FSM state and output registers.
  always_ff @(posedge clk or negedge sys_rst_n_s) begin
    if (!sys_rst_n_s) begin
      state_r      <= IDLE;
      hold_cnt_r   <= '0;
      mode_sys_r   <= MODE_RST;
      long_press_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      mode_sys_r   <= mode_sys_nxt_s;
      long_press_r <= long_press_nxt_s;
    end
  end

  // Press classification: release before the threshold is a short press.
  always_comb begin
    state_nxt_s      = state_r;
    hold_cnt_nxt_s   = hold_cnt_r;
    mode_sys_nxt_s   = mode_sys_r;
    long_press_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pressed_s) begin
          state_nxt_s    = HOLD;
          hold_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (!pressed_s) begin
          state_nxt_s    = IDLE;
          mode_sys_nxt_s = (mode_sys_r == LAST_MODE) ? MODE_RST : mode_sys_r + MODE_W'(1);
        end else if (hold_cnt_r == HOLD_W'(LONG_CYC - 1)) begin
          state_nxt_s      = WAIT_REL;
          mode_sys_nxt_s   = MODE_RST;
          long_press_nxt_s = 1'b1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      WAIT_REL: begin
        if (!pressed_s) state_nxt_s = IDLE;
        else            state_nxt_s = WAIT_REL;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request side: ship the latest mode whenever idle; xfer_data holds while busy.
  always_ff @(posedge clk or negedge sys_rst_n_s) begin
    if (!sys_rst_n_s) begin
      ack_sync_r  <= 3'b000;
      sent_r      <= MODE_RST;
      xfer_data_r <= MODE_RST;
      req_tgl_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      ack_sync_r <= {ack_sync_r[1:0], ack_tgl_r};
      if (busy_r) begin
        if (ack_sync_r[2] != ack_sync_r[1]) begin
          sent_r <= xfer_data_r;
          busy_r <= 1'b0;
        end else begin
          busy_r <= 1'b1;
        end
      end else if (mode_sys_r != sent_r) begin
        xfer_data_r <= mode_sys_r;
        req_tgl_r   <= ~req_tgl_r;
        busy_r      <= 1'b1;
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  assign cap_s = req_sync_r[2] ^ req_sync_r[1];

  // Video side: capture on request toggle, apply pending mode on registered vsync edge.
  always_ff @(posedge vid_clk or negedge vid_rst_n_s) begin
    if (!vid_rst_n_s) begin
      req_sync_r     <= 3'b000;
      ack_tgl_r      <= 1'b0;
      pend_r         <= 1'b0;
      pend_mode_r    <= MODE_RST;
      mode_out_r     <= MODE_RST;
      mode_changed_r <= 1'b0;
      vs_in_r        <= 1'b0;
      vs_prev_r      <= 1'b0;
      vs_edge_r      <= 1'b0;
    end else begin
      req_sync_r <= {req_sync_r[1:0], req_tgl_r};
      vs_in_r    <= (vid_vsync == VSYNC_POL);
      vs_prev_r  <= vs_in_r;
      vs_edge_r  <= vs_in_r & ~vs_prev_r;
      if (vs_edge_r && pend_r) begin
        mode_out_r     <= pend_mode_r;
        mode_changed_r <= 1'b1;
      end else begin
        mode_changed_r <= 1'b0;
      end
      if (cap_s) begin
        pend_mode_r <= xfer_data_r;
        pend_r      <= 1'b1;
        ack_tgl_r   <= ~ack_tgl_r;
      end else if (vs_edge_r) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign mode_sys     = mode_sys_r;
  assign long_press   = long_press_r;
  assign mode_out     = mode_out_r;
  assign mode_changed = mode_changed_r;

endmodule
